// File: rtl/alu_issue_queue.sv
// Reservation station ahead of a single ALU: holds renamed ops until their sources
// are ready, then issues the oldest ready op each cycle from a compacting queue.
module alu_issue_queue #(
    parameter int NENTRY     = 8,
    parameter int LNENTRY    = 3,
    parameter int NCOMMIT    = 32,
    parameter int LNCOMMIT   = 5,
    parameter int CNTRL_SIZE = 7,
    parameter int VA_SZ      = 48,
    parameter int NWAKE      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CNTRL_SIZE-1:0]     in_control,
    input  logic [LNCOMMIT-1:0]       in_rd,
    input  logic                      in_makes_rd,
    input  logic                      in_needs_rs2,
    input  logic [LNCOMMIT-1:0]       in_rs1,
    input  logic [LNCOMMIT-1:0]       in_rs2,
    input  logic                      in_rs1_ready,
    input  logic                      in_rs2_ready,
    input  logic [VA_SZ-1:1]          in_pc,
    input  logic [31:0]               in_immed,
    input  logic [NWAKE-1:0]          wake_valid,
    input  logic [NWAKE*LNCOMMIT-1:0] wake_rd,
    input  logic [NCOMMIT-1:0]        commit_kill,
    output logic                      enable,
    output logic [CNTRL_SIZE-1:0]     control,
    output logic [LNCOMMIT-1:0]       rd,
    output logic                      makes_rd,
    output logic                      needs_rs2,
    output logic [VA_SZ-1:1]          pc,
    output logic [31:0]               immed,
    output logic [LNCOMMIT-1:0]       rs1_addr,
    output logic [LNCOMMIT-1:0]       rs2_addr,
    output logic [LNENTRY:0]          count
);

    typedef struct packed {
        logic                  valid;
        logic [CNTRL_SIZE-1:0] control;
        logic [LNCOMMIT-1:0]   rd;
        logic                  makes_rd;
        logic                  needs_rs2;
        logic [LNCOMMIT-1:0]   rs1;
        logic [LNCOMMIT-1:0]   rs2;
        logic [VA_SZ-1:1]      pc;
        logic [31:0]           immed;
        logic                  r1ok;
        logic                  r2ok;
    } entry_t;

    entry_t           q_q [NENTRY];
    entry_t           q_d [NENTRY];
    logic [LNENTRY:0] count_q, count_d;
    logic [NENTRY-1:0] elig, keep;
    logic [LNENTRY-1:0] sel;
    logic             accept;
    entry_t           upd, new_e;
    logic [LNENTRY:0] wr;

    function automatic logic wake_hit(input logic [LNCOMMIT-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NWAKE; k++) begin
            if (wake_valid[k] && (wake_rd[k*LNCOMMIT +: LNCOMMIT] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        elig = '0;
        for (int i = 0; i < NENTRY; i++) begin
            elig[i] = q_q[i].valid & q_q[i].r1ok & q_q[i].r2ok & ~commit_kill[q_q[i].rd];
        end
    end

    // Priority search from the top so the lowest eligible index wins.
    always_comb begin
        sel = '0;
        for (int i = NENTRY - 1; i >= 0; i--) begin
            if (elig[i]) sel = LNENTRY'(i);
        end
    end

    assign enable    = |elig;
    assign control   = q_q[sel].control;
    assign rd        = q_q[sel].rd;
    assign makes_rd  = enable & q_q[sel].makes_rd;
    assign needs_rs2 = q_q[sel].needs_rs2;
    assign pc        = q_q[sel].pc;
    assign immed     = q_q[sel].immed;
    assign rs1_addr  = q_q[sel].rs1;
    assign rs2_addr  = q_q[sel].rs2;
    assign count     = count_q;
    assign in_ready  = (count_q < (LNENTRY+1)'(NENTRY));

    always_comb begin
        keep = '0;
        for (int i = 0; i < NENTRY; i++) begin
            keep[i] = q_q[i].valid & ~commit_kill[q_q[i].rd] & ~(enable && (sel == LNENTRY'(i)));
        end
    end

    assign accept = in_valid & in_ready & ~commit_kill[in_rd];

    always_comb begin
        new_e           = '0;
        new_e.valid     = 1'b1;
        new_e.control   = in_control;
        new_e.rd        = in_rd;
        new_e.makes_rd  = in_makes_rd;
        new_e.needs_rs2 = in_needs_rs2;
        new_e.rs1       = in_rs1;
        new_e.rs2       = in_rs2;
        new_e.pc        = in_pc;
        new_e.immed     = in_immed;
        new_e.r1ok      = in_rs1_ready | wake_hit(in_rs1);
        new_e.r2ok      = ~in_needs_rs2 | in_rs2_ready | wake_hit(in_rs2);
    end

    // Survivors are packed down in order; the new op lands just above them.
    always_comb begin
        q_d = '{default: '0};
        upd = '0;
        wr  = '0;
        for (int i = 0; i < NENTRY; i++) begin
            upd      = q_q[i];
            upd.r1ok = q_q[i].r1ok | wake_hit(q_q[i].rs1);
            upd.r2ok = q_q[i].r2ok | wake_hit(q_q[i].rs2);
            if (keep[i]) begin
                q_d[wr[LNENTRY-1:0]] = upd;
                wr = wr + 1'b1;
            end
        end
        if (accept) begin
            q_d[wr[LNENTRY-1:0]] = new_e;
            wr = wr + 1'b1;
        end
        count_d = wr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < NENTRY; i++) q_q[i] <= '0;
        end else begin
            count_q <= count_d;
            q_q     <= q_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios plus random traffic, all checked by a
// queue-based reference model feeding a per-cycle scoreboard.
module tb_alu_issue_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_control;
    logic [4:0]  in_rd;
    logic        in_makes_rd;
    logic        in_needs_rs2;
    logic [4:0]  in_rs1, in_rs2;
    logic        in_rs1_ready, in_rs2_ready;
    logic [47:1] in_pc;
    logic [31:0] in_immed;
    logic [1:0]  wake_valid;
    logic [9:0]  wake_rd;
    logic [31:0] commit_kill;
    logic        enable;
    logic [6:0]  control;
    logic [4:0]  rd;
    logic        makes_rd, needs_rs2;
    logic [47:1] pc;
    logic [31:0] immed;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [3:0]  count;

    alu_issue_queue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_control(in_control), .in_rd(in_rd), .in_makes_rd(in_makes_rd),
        .in_needs_rs2(in_needs_rs2), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_ready(in_rs1_ready), .in_rs2_ready(in_rs2_ready), .in_pc(in_pc),
        .in_immed(in_immed), .wake_valid(wake_valid), .wake_rd(wake_rd),
        .commit_kill(commit_kill), .enable(enable), .control(control), .rd(rd),
        .makes_rd(makes_rd), .needs_rs2(needs_rs2), .pc(pc), .immed(immed),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of waiting ops with per-source ready flags.
    typedef struct {
        logic [6:0]  control;
        logic [4:0]  rd;
        logic        makes_rd;
        logic        needs_rs2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [47:1] pc;
        logic [31:0] immed;
        bit          ok1;
        bit          ok2;
    } mop_t;

    mop_t         mq[$];
    logic [108:0] exp_q[$];
    logic [108:0] mon_e;
    int           n_checks = 0;
    int           n_fail   = 0;
    bit           mon_en   = 1'b0;
    int           iss_idx;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit woke(input logic [4:0] tag);
        return (wake_valid[0] && wake_rd[4:0] == tag) || (wake_valid[1] && wake_rd[9:5] == tag);
    endfunction

    task automatic idle();
        in_valid     = 1'b0;
        in_control   = '0;
        in_rd        = '0;
        in_makes_rd  = 1'b0;
        in_needs_rs2 = 1'b0;
        in_rs1       = '0;
        in_rs2       = '0;
        in_rs1_ready = 1'b0;
        in_rs2_ready = 1'b0;
        in_pc        = '0;
        in_immed     = '0;
        wake_valid   = '0;
        wake_rd      = '0;
        commit_kill  = '0;
    endtask

    task automatic drive_op(input logic [4:0] r, input logic [4:0] s1, input logic [4:0] s2,
                            input logic r1, input logic r2, input logic n2);
        in_valid     = 1'b1;
        in_rd        = r;
        in_rs1       = s1;
        in_rs2       = s2;
        in_rs1_ready = r1;
        in_rs2_ready = r2;
        in_needs_rs2 = n2;
        in_control   = 7'($urandom());
        in_makes_rd  = 1'($urandom());
        in_pc        = 47'({$urandom(), $urandom()});
        in_immed     = $urandom();
    endtask

    task automatic wake(input int port, input logic [4:0] tag);
        wake_valid[port]      = 1'b1;
        wake_rd[port*5 +: 5]  = tag;
    endtask

    // Expected view of the current cycle, built from the model before the edge.
    task automatic model_eval();
        logic [102:0] iss;
        logic         en;
        iss     = '0;
        en      = 1'b0;
        iss_idx = -1;
        foreach (mq[i]) begin
            if (iss_idx < 0 && mq[i].ok1 && mq[i].ok2 && !commit_kill[mq[i].rd]) iss_idx = i;
        end
        if (iss_idx >= 0) begin
            en  = 1'b1;
            iss = {mq[iss_idx].control, mq[iss_idx].rd, mq[iss_idx].makes_rd, mq[iss_idx].needs_rs2,
                   mq[iss_idx].rs1, mq[iss_idx].rs2, mq[iss_idx].pc, mq[iss_idx].immed};
        end
        exp_q.push_back({en, iss, 4'(mq.size()), (mq.size() < 8) ? 1'b1 : 1'b0});
    endtask

    task automatic model_commit();
        mop_t n;
        bit   acc;
        acc = in_valid && (mq.size() < 8);
        if (iss_idx >= 0) mq.delete(iss_idx);
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (commit_kill[mq[i].rd]) mq.delete(i);
        end
        foreach (mq[i]) begin
            if (woke(mq[i].rs1)) mq[i].ok1 = 1'b1;
            if (woke(mq[i].rs2)) mq[i].ok2 = 1'b1;
        end
        if (acc && !commit_kill[in_rd]) begin
            n.control   = in_control;
            n.rd        = in_rd;
            n.makes_rd  = in_makes_rd;
            n.needs_rs2 = in_needs_rs2;
            n.rs1       = in_rs1;
            n.rs2       = in_rs2;
            n.pc        = in_pc;
            n.immed     = in_immed;
            n.ok1       = in_rs1_ready || woke(in_rs1);
            n.ok2       = !in_needs_rs2 || in_rs2_ready || woke(in_rs2);
            mq.push_back(n);
        end
    endtask

    // One clock: inputs are already driven; they return to idle 1 time unit after the edge.
    task automatic step();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
        idle();
    endtask

    task automatic flush();
        commit_kill = '1;
        step();
    endtask

    always @(negedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("enable", enable, mon_e[108]);
            if (enable && mon_e[108])
                check("issue", {control, rd, makes_rd, needs_rs2, rs1_addr, rs2_addr, pc, immed}, mon_e[107:5]);
            else if (!enable)
                check("makes_rd_idle", makes_rd, 0);
            check("count", count, mon_e[4:1]);
            check("in_ready", in_ready, mon_e[0]);
        end
    end

    initial begin
        idle();
        reset = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_enable", enable, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        // Ready dispatch
        drive_op(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
        step();
        check("rdy_enable", enable, 1);
        check("rdy_rd", rd, 3);
        check("rdy_rs1", rs1_addr, 1);
        check("rdy_rs2", rs2_addr, 2);
        step();
        check("rdy_count", count, 0);

        // Wakeup after waiting, and wake in the enqueue cycle
        drive_op(5'd20, 5'd7, 5'd2, 1'b0, 1'b1, 1'b1);
        step();
        repeat (3) begin
            check("wait_enable", enable, 0);
            step();
        end
        wake(1, 5'd7);
        step();
        check("wake_enable", enable, 1);
        check("wake_rd", rd, 20);
        step();
        drive_op(5'd21, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1);
        wake(0, 5'd7);
        step();
        check("samecyc_enable", enable, 1);
        check("samecyc_rd", rd, 21);
        step();

        // Oldest first
        drive_op(5'd4, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0); step();
        drive_op(5'd5, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0); step();
        drive_op(5'd6, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0); step();
        wake(0, 5'd9);
        step();
        check("order_a", rd, 4); step();
        check("order_b", rd, 5); step();
        check("order_c", rd, 6); step();
        check("order_count", count, 0);

        // Full queue; an op offered while full is not taken
        for (int i = 0; i < 8; i++) begin
            drive_op(5'(i), 5'(16 + i), 5'd0, 1'b0, 1'b1, 1'b1);
            step();
        end
        check("full_in_ready", in_ready, 0);
        check("full_count", count, 8);
        wake(0, 5'd16);
        drive_op(5'd30, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        check("full_issue_en", enable, 1);
        check("full_issue_ready", in_ready, 0);
        step();
        check("full_after_count", count, 7);
        check("full_after_ready", in_ready, 1);
        flush();

        // Kill in the middle of a group, then kill of the selected op
        drive_op(5'd10, 5'd13, 5'd0, 1'b0, 1'b1, 1'b1); step();
        drive_op(5'd11, 5'd13, 5'd0, 1'b0, 1'b1, 1'b1); step();
        drive_op(5'd12, 5'd13, 5'd0, 1'b0, 1'b1, 1'b1); step();
        wake(0, 5'd13);
        step();
        commit_kill[11] = 1'b1;
        check("kill_first", rd, 10);
        step();
        check("kill_second", rd, 12);
        step();
        check("kill_count", count, 0);
        drive_op(5'd14, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        step();
        commit_kill[14] = 1'b1;
        #1;
        check("kill_sel_enable", enable, 0);
        step();
        drive_op(5'd15, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        commit_kill[15] = 1'b1;
        step();
        check("kill_incoming_count", count, 0);

        // Asynchronous reset with 5 ops held
        for (int i = 0; i < 5; i++) begin
            drive_op(5'(20 + i), 5'd25, 5'd0, 1'b0, 1'b1, 1'b1);
            step();
        end
        check("pre_rst_count", count, 5);
        mon_en = 1'b0;
        exp_q.delete();
        #2;
        reset = 1'b0;
        #1;
        check("async_count", count, 0);
        check("async_enable", enable, 0);
        check("async_makes_rd", makes_rd, 0);
        check("async_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        mq.delete();
        mon_en = 1'b1;
        wake(0, 5'd25);
        step();
        check("stale_enable", enable, 0);
        step();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) < 6)
                drive_op(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 9) < 4) wake(k, 5'($urandom_range(0, 31)));
            end
            if ($urandom_range(0, 19) == 0) commit_kill[$urandom_range(0, 31)] = 1'b1;
            step();
        end
        flush();
        step();

        @(negedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
